// File: rtl/q_pulse_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : q_pulse_counter_if
// Description : Signal bundle between the Q pulse-train source and the
//               q_pulse_counter receiver.
//               master : drives start / q_serial, observes the result
//               slave  : the counter itself
//   start      - measurement enable, 0->1 arms one measurement
//   q_serial   - asynchronous serialized Q pulse train, idles low
//   q_measured - reconstructed Q (count x Q_PER_PULSE), saturated
//   n_pulses   - raw pulse count of the last completed burst
//   q_valid    - one-cycle strobe, result fields updated
//   overflow   - last result saturated
//   busy       - measurement in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface q_pulse_counter_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 start;
  logic                 q_serial;
  logic [BUS_WIDTH-1:0] q_measured;
  logic [BUS_WIDTH-1:0] n_pulses;
  logic                 q_valid;
  logic                 overflow;
  logic                 busy;

  modport master (
    output start,
    output q_serial,
    input  q_measured,
    input  n_pulses,
    input  q_valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  start,
    input  q_serial,
    output q_measured,
    output n_pulses,
    output q_valid,
    output overflow,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/q_pulse_counter.sv
`default_nettype none
// ============================================================================
// Module      : q_pulse_counter
// Description : Receive end of the resonant-system emulation link. Samples
//               the asynchronous Q pulse train, counts rising edges of one
//               burst and reconstructs Q = count x Q_PER_PULSE (saturated).
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - q_pulse_counter_if.slave
//                        (start, q_serial in; q_measured, n_pulses,
//                         q_valid, overflow, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module q_pulse_counter #(
  parameter int BUS_WIDTH    = 10,
  parameter int Q_PER_PULSE  = 30,
  parameter int IDLE_TIMEOUT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  q_pulse_counter_if.slave bus
);

  localparam int c_PROD_W = BUS_WIDTH + $clog2(Q_PER_PULSE + 1);
  localparam int c_IDLE_W = $clog2(IDLE_TIMEOUT);

  localparam logic [BUS_WIDTH-1:0] c_CNT_MAX   = '1;
  localparam logic [c_PROD_W-1:0]  c_PROD_MAX  = c_PROD_W'(c_CNT_MAX);
  localparam logic [c_PROD_W-1:0]  c_Q_PER_P   = c_PROD_W'(Q_PER_PULSE);
  localparam logic [c_IDLE_W-1:0]  c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_edge_q;
  logic                   r_start_d;
  logic                   w_start_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_hist    <= 1'b0;
      r_edge_q  <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.q_serial};
      r_hist    <= r_sync[SYNC_STAGES-1];
      r_edge_q  <= r_sync[SYNC_STAGES-1] & ~r_hist;
      r_start_d <= bus.start;
    end
  end

  assign w_start_rise = bus.start & ~r_start_d;

  // --------------------------------------------------------------------------
  // Measurement FSM and datapath
  // --------------------------------------------------------------------------
  state_t               r_state,    w_state_nx;
  logic [BUS_WIDTH-1:0] r_count,    w_count_nx;
  logic [c_IDLE_W-1:0]  r_idle_cnt, w_idle_nx;
  logic                 r_sat,      w_sat_nx;
  logic [BUS_WIDTH-1:0] r_q_meas,   w_q_meas_nx;
  logic [BUS_WIDTH-1:0] r_n_pulses, w_n_pulses_nx;
  logic                 r_ovf,      w_ovf_nx;
  logic                 r_valid,    w_valid_nx;
  logic [c_PROD_W-1:0]  w_product;
  logic                 w_prod_sat;

  assign w_product  = c_PROD_W'(r_count) * c_Q_PER_P;
  assign w_prod_sat = (w_product > c_PROD_MAX);

  always_comb begin
    w_state_nx    = r_state;
    w_count_nx    = r_count;
    w_idle_nx     = r_idle_cnt;
    w_sat_nx      = r_sat;
    w_q_meas_nx   = r_q_meas;
    w_n_pulses_nx = r_n_pulses;
    w_ovf_nx      = r_ovf;
    w_valid_nx    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_nx = S_ARMED;
          w_count_nx = '0;
          w_idle_nx  = '0;
          w_sat_nx   = 1'b0;
        end
      end

      S_ARMED: begin
        // Abort wins; an edge arriving in the same cycle is dropped.
        if (!bus.start) begin
          w_state_nx = S_IDLE;
        end else if (r_edge_q) begin
          w_state_nx = S_COUNT;
          w_count_nx = BUS_WIDTH'(1);
          w_idle_nx  = '0;
        end
      end

      S_COUNT: begin
        if (!bus.start) begin
          w_state_nx = S_IDLE;
        end else if (r_edge_q) begin
          w_idle_nx = '0;
          if (r_count == c_CNT_MAX) begin
            w_sat_nx = 1'b1;
          end else begin
            w_count_nx = r_count + BUS_WIDTH'(1);
          end
        end else if (r_idle_cnt == c_IDLE_LAST) begin
          // Result is loaded on the way into DONE so that the registered
          // outputs and q_valid are present during the single DONE cycle.
          w_state_nx    = S_DONE;
          w_q_meas_nx   = w_prod_sat ? c_CNT_MAX : w_product[BUS_WIDTH-1:0];
          w_n_pulses_nx = r_count;
          w_ovf_nx      = r_sat | w_prod_sat;
          w_valid_nx    = 1'b1;
        end else begin
          w_idle_nx = r_idle_cnt + c_IDLE_W'(1);
        end
      end

      S_DONE: begin
        w_state_nx = S_IDLE;
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_idle_cnt <= '0;
      r_sat      <= 1'b0;
      r_q_meas   <= '0;
      r_n_pulses <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_count    <= w_count_nx;
      r_idle_cnt <= w_idle_nx;
      r_sat      <= w_sat_nx;
      r_q_meas   <= w_q_meas_nx;
      r_n_pulses <= w_n_pulses_nx;
      r_ovf      <= w_ovf_nx;
      r_valid    <= w_valid_nx;
    end
  end

  assign bus.q_measured = r_q_meas;
  assign bus.n_pulses   = r_n_pulses;
  assign bus.q_valid    = r_valid;
  assign bus.overflow   = r_ovf;
  assign bus.busy       = (r_state == S_ARMED) || (r_state == S_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_q_pulse_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_q_pulse_counter
// Description : Self-checking bench for q_pulse_counter. A 10-bit and a 4-bit
//               instance share the same start / q_serial stimulus; expected
//               results come from a pulse-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_pulse_counter;

  localparam int BW  = 10;
  localparam int BW4 = 4;
  localparam int QP  = 30;
  localparam int T   = 16;
  localparam int SY  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic q_serial = 1'b0;

  q_pulse_counter_if #(.BUS_WIDTH(BW))  if10 ();
  q_pulse_counter_if #(.BUS_WIDTH(BW4)) if4 ();

  assign if10.start    = start;
  assign if10.q_serial = q_serial;
  assign if4.start     = start;
  assign if4.q_serial  = q_serial;

  q_pulse_counter #(.BUS_WIDTH(BW), .Q_PER_PULSE(QP), .IDLE_TIMEOUT(T), .SYNC_STAGES(SY))
    u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));
  q_pulse_counter #(.BUS_WIDTH(BW4), .Q_PER_PULSE(QP), .IDLE_TIMEOUT(T), .SYNC_STAGES(SY))
    u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid10 = 0;
  int nvalid4 = 0;
  int last_valid_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if10.q_valid === 1'b1) begin
      nvalid10       <= nvalid10 + 1;
      last_valid_cyc <= cyc;
    end
    if (if4.q_valid === 1'b1) nvalid4 <= nvalid4 + 1;
  end

  // Pulse description for the next burst, and the posedge index at which
  // each rising edge is first sampled.
  int pulse_hi[$];
  int pulse_lo[$];
  int rise_q[$];

  // Expected held outputs.
  int e_n10 = 0, e_q10 = 0, e_o10 = 0;
  int e_n4 = 0, e_q4 = 0, e_o4 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Spec-level result for n counted pulses on a w-bit receiver.
  task automatic expect_for(input int n, input int w, output int en, output int eq, output int eo);
    int mx;
    int prod;
    mx   = (1 << w) - 1;
    en   = (n > mx) ? mx : n;
    prod = en * QP;
    eq   = (prod > mx) ? mx : prod;
    eo   = ((n > mx) || (prod > mx)) ? 1 : 0;
  endtask

  task automatic check_outputs(input string lbl);
    chk({lbl, ".n10"},  32'(if10.n_pulses),   32'(e_n10));
    chk({lbl, ".q10"},  32'(if10.q_measured), 32'(e_q10));
    chk({lbl, ".ov10"}, 32'(if10.overflow),   32'(e_o10));
    chk({lbl, ".n4"},   32'(if4.n_pulses),    32'(e_n4));
    chk({lbl, ".q4"},   32'(if4.q_measured),  32'(e_q4));
    chk({lbl, ".ov4"},  32'(if4.overflow),    32'(e_o4));
  endtask

  task automatic random_pulses(input int n);
    pulse_hi.delete();
    pulse_lo.delete();
    for (int i = 0; i < n; i++) begin
      int h;
      h = int'($urandom_range(3, 8));
      pulse_hi.push_back(h);
      pulse_lo.push_back(int'($urandom_range(3, T - h)));
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic drive_pulses();
    rise_q.delete();
    for (int i = 0; i < pulse_hi.size(); i++) begin
      rise_q.push_back(cyc + 1);
      q_serial = 1'b1;
      repeat (pulse_hi[i]) @(negedge clk);
      q_serial = 1'b0;
      repeat (pulse_lo[i]) @(negedge clk);
    end
  endtask

  task automatic arm();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_measure(input string lbl);
    int nv10_0, nv4_0, n, exp_cyc;
    nv10_0 = nvalid10;
    nv4_0  = nvalid4;
    drive_pulses();
    // A burst continues while the rising-edge spacing stays within T cycles.
    n = 0;
    for (int i = 0; i < pulse_hi.size(); i++) begin
      if (i == 0) n = 1;
      else if (pulse_hi[i-1] + pulse_lo[i-1] <= T) n++;
      else break;
    end
    exp_cyc = rise_q[n-1] + SY + T + 1;
    repeat (T + SY + 6) @(negedge clk);
    expect_for(n, BW,  e_n10, e_q10, e_o10);
    expect_for(n, BW4, e_n4,  e_q4,  e_o4);
    chk({lbl, ".nvalid10"}, 32'(nvalid10 - nv10_0), 32'd1);
    chk({lbl, ".nvalid4"},  32'(nvalid4 - nv4_0),   32'd1);
    chk({lbl, ".vcyc"},     32'(last_valid_cyc),    32'(exp_cyc));
    chk({lbl, ".busy"},     32'(if10.busy),         32'd0);
    check_outputs(lbl);
  endtask

  initial begin
    int nv0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(if10.q_valid), 32'd0);
    chk("rst.busy",  32'(if10.busy),    32'd0);
    check_outputs("rst");
    rst_n = 1'b1;

    // Five 8/8 pulses
    arm();
    chk("arm.busy", 32'(if10.busy), 32'd1);
    pulse_hi = '{8, 8, 8, 8, 8};
    pulse_lo = '{8, 8, 8, 8, 8};
    do_measure("p5");

    // Single pulse, then 34 random pulses
    arm();
    pulse_hi = '{5};
    pulse_lo = '{6};
    do_measure("p1");
    arm();
    random_pulses(34);
    do_measure("p34");

    // Product saturation (and count saturation on the 4-bit instance)
    arm();
    random_pulses(35);
    do_measure("p35");
    arm();
    random_pulses(20);
    do_measure("p20");

    // Abort mid-burst: no result, outputs hold
    arm();
    nv0 = nvalid10;
    pulse_hi = '{4, 4, 4};
    pulse_lo = '{4, 4, 4};
    drive_pulses();
    start = 1'b0;
    repeat (T + SY + 8) @(negedge clk);
    chk("abort.nvalid", 32'(nvalid10 - nv0), 32'd0);
    chk("abort.busy",   32'(if10.busy),      32'd0);
    check_outputs("abort");

    // Asynchronous reset mid-count
    arm();
    nv0 = nvalid10;
    pulse_hi = '{5, 5, 5, 5};
    pulse_lo = '{5, 5, 5, 5};
    drive_pulses();
    #2 rst_n = 1'b0;
    #1;
    e_n10 = 0; e_q10 = 0; e_o10 = 0;
    e_n4 = 0;  e_q4 = 0;  e_o4 = 0;
    chk("arst.busy", 32'(if10.busy), 32'd0);
    check_outputs("arst");
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (T + SY + 4) @(negedge clk);
    chk("arst.nvalid", 32'(nvalid10 - nv0), 32'd0);
    arm();
    pulse_hi = '{6, 6};
    pulse_lo = '{6, 6};
    do_measure("p2");

    // Long wait in ARMED, then a split burst
    arm();
    nv0 = nvalid10;
    repeat (1000) @(negedge clk);
    chk("wait.busy",   32'(if10.busy),      32'd1);
    chk("wait.nvalid", 32'(nvalid10 - nv0), 32'd0);
    pulse_hi = '{5, 5, 5, 5, 5};
    pulse_lo = '{5, 5, T + 4, 5, 5};
    do_measure("split");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
